// File: rtl/functional_lane_apply.sv
// functional_lane_apply
//   Partner-side half of the functional-lane decision during mainband repair.
//   It waits for the remote die's functional-lane sideband message and decodes
//   the remote 2-bit lane code into the RX lane-enable mask. It decodes the
//   local code into the TX mask, then returns ACK/NAK over a valid/ready
//   handshake.
//
//   Lane code: 11 all lanes, 10 upper half, 01 lower half, 00 none.
//
//   Optional build macro FLA_SYMMETRIC_EN: both masks become the AND of the two
//   decoded masks, so the link runs at the common width. If that AND is empty,
//   the response is NAK and o_error is set.
//
// Ports
//   CLK, rst_n        clock; asynchronous active-low reset
//   start_apply       single-cycle start, honoured only in IDLE
//   i_local_lanes     local TX lane code
//   i_sb_msg_valid    remote lane message present (accepted only in WAIT_MSG)
//   i_sb_msg_lanes    remote TX lane code
//   i_sb_resp_ready   sideband accepts the response
//   o_rx_lane_enable  RX lane mask
//   o_tx_lane_enable  TX lane mask
//   o_sb_resp_valid   response valid
//   o_sb_resp_code    01 ACK, 10 NAK
//   o_width_degraded  either mask is not all-ones
//   o_error           sticky error, cleared by an accepted start
//   o_timeout         sticky timeout, cleared by an accepted start
//   done_apply        one-cycle completion pulse
//   dbg_state         current FSM state (IDLE=0, WAIT_MSG=1, RESP=2, DONE=3)
//
// Handshake: a response transfers on the rising edge where o_sb_resp_valid and
// i_sb_resp_ready are both high. Once valid is raised, it stays high and
// o_sb_resp_code stays stable until that transfer. Valid drops in the
// following cycle. Ready never influences valid.
module functional_lane_apply #(
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int NUM_LANES      = 16
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 start_apply,
  input  logic [1:0]           i_local_lanes,
  input  logic                 i_sb_msg_valid,
  input  logic [1:0]           i_sb_msg_lanes,
  input  logic                 i_sb_resp_ready,
  output logic [NUM_LANES-1:0] o_rx_lane_enable,
  output logic [NUM_LANES-1:0] o_tx_lane_enable,
  output logic                 o_sb_resp_valid,
  output logic [1:0]           o_sb_resp_code,
  output logic                 o_width_degraded,
  output logic                 o_error,
  output logic                 o_timeout,
  output logic                 done_apply,
  output logic [1:0]           dbg_state
);

  localparam int HALF = NUM_LANES / 2;
  localparam int CW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0]        CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_LANES-1:0] ALL_ONES  = '1;
  localparam logic [1:0]           CODE_ACK  = 2'b01;
  localparam logic [1:0]           CODE_NAK  = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MSG = 2'd1,
    RESP     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  function automatic logic [NUM_LANES-1:0] decode_lanes(input logic [1:0] code);
    logic [NUM_LANES-1:0] m;
    m = '0;
    if (code[1]) m[NUM_LANES-1:HALF] = '1;
    if (code[0]) m[HALF-1:0]         = '1;
    return m;
  endfunction

  // Candidate masks and verdict for a message accepted this cycle.
  logic [NUM_LANES-1:0] dec_rx, dec_tx, new_rx, new_tx;
  logic                 new_ok;

  always_comb begin
    dec_rx = decode_lanes(i_sb_msg_lanes);
    dec_tx = decode_lanes(i_local_lanes);
`ifdef FLA_SYMMETRIC_EN
    new_rx = dec_rx & dec_tx;
    new_tx = new_rx;
    new_ok = |new_rx;
`else
    new_rx = dec_rx;
    new_tx = dec_tx;
    new_ok = (|i_sb_msg_lanes) && (|i_local_lanes);
`endif
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      o_rx_lane_enable <= ALL_ONES;
      o_tx_lane_enable <= ALL_ONES;
      o_sb_resp_valid  <= 1'b0;
      o_sb_resp_code   <= 2'b00;
      o_width_degraded <= 1'b0;
      o_error          <= 1'b0;
      o_timeout        <= 1'b0;
      done_apply       <= 1'b0;
    end else begin
      done_apply <= 1'b0;
      case (state)
        IDLE: begin
          // Remote messages that arrive here are dropped, not buffered.
          if (start_apply) begin
            state     <= WAIT_MSG;
            cnt       <= '0;
            o_error   <= 1'b0;
            o_timeout <= 1'b0;
          end
        end
        WAIT_MSG: begin
          // A message takes priority over a timeout that expires in the same cycle.
          if (i_sb_msg_valid) begin
            o_rx_lane_enable <= new_rx;
            o_tx_lane_enable <= new_tx;
            o_width_degraded <= (new_rx != ALL_ONES) || (new_tx != ALL_ONES);
            o_sb_resp_valid  <= 1'b1;
            o_sb_resp_code   <= new_ok ? CODE_ACK : CODE_NAK;
            if (!new_ok) o_error <= 1'b1;
            state <= RESP;
          end else if (cnt == CNT_LAST) begin
            o_error   <= 1'b1;
            o_timeout <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (i_sb_resp_ready) begin
            o_sb_resp_valid <= 1'b0;
            state           <= DONE;
          end
        end
        DONE: begin
          done_apply <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_functional_lane_apply.sv
module tb_functional_lane_apply;

  localparam int TMO = 16;
  localparam int NL  = 16;

  logic          CLK;
  logic          rst_n;
  logic          start_apply;
  logic [1:0]    i_local_lanes;
  logic          i_sb_msg_valid;
  logic [1:0]    i_sb_msg_lanes;
  logic          i_sb_resp_ready;
  logic [NL-1:0] o_rx_lane_enable;
  logic [NL-1:0] o_tx_lane_enable;
  logic          o_sb_resp_valid;
  logic [1:0]    o_sb_resp_code;
  logic          o_width_degraded;
  logic          o_error;
  logic          o_timeout;
  logic          done_apply;
  logic [1:0]    dbg_state;

  functional_lane_apply #(.TIMEOUT_CYCLES(TMO), .NUM_LANES(NL)) dut (
    .CLK              (CLK),
    .rst_n            (rst_n),
    .start_apply      (start_apply),
    .i_local_lanes    (i_local_lanes),
    .i_sb_msg_valid   (i_sb_msg_valid),
    .i_sb_msg_lanes   (i_sb_msg_lanes),
    .i_sb_resp_ready  (i_sb_resp_ready),
    .o_rx_lane_enable (o_rx_lane_enable),
    .o_tx_lane_enable (o_tx_lane_enable),
    .o_sb_resp_valid  (o_sb_resp_valid),
    .o_sb_resp_code   (o_sb_resp_code),
    .o_width_degraded (o_width_degraded),
    .o_error          (o_error),
    .o_timeout        (o_timeout),
    .done_apply       (done_apply),
    .dbg_state        (dbg_state)
  );

  // Clock / watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: act=still running req=finished");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard
  int total = 0;
  int bad   = 0;
  logic [1:0]    exp_q[$];
  logic [NL-1:0] last_rx = '1;
  logic [NL-1:0] last_tx = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h req=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model, computed from the lane-code meaning
  function automatic logic [NL-1:0] model_mask(input logic [1:0] code);
    int unsigned full, lo, hi;
    full = (1 << NL) - 1;
    lo   = (1 << (NL / 2)) - 1;
    hi   = full - lo;
    return NL'((code[1] ? hi : 0) + (code[0] ? lo : 0));
  endfunction

  task automatic model(input logic [1:0] rem, input logic [1:0] loc,
                       output logic [NL-1:0] rx, output logic [NL-1:0] tx,
                       output logic [1:0] code, output bit err, output bit deg);
    bit ok;
    rx = model_mask(rem);
    tx = model_mask(loc);
`ifdef FLA_SYMMETRIC_EN
    rx = rx & tx;
    tx = rx;
    ok = (rx != 0);
`else
    ok = (rem != 0) && (loc != 0);
`endif
    code = ok ? 2'b01 : 2'b10;
    err  = !ok;
    deg  = (rx != {NL{1'b1}}) || (tx != {NL{1'b1}});
  endtask

  // Driver tasks (inputs change 1 time unit after the rising edge, outputs sampled there)
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_txn(input logic [1:0] rem, input logic [1:0] loc,
                         input int wt, input int rd, input bit poke,
                         input logic [NL-1:0] erx, input logic [NL-1:0] etx,
                         input logic [1:0] ecode, input bit eerr, input bit edeg);
    // Ready raised early when rd==0; it must not matter before valid.
    i_sb_resp_ready = (rd == 0);
    start_apply = 1'b1;
    tick();
    start_apply = 1'b0;
    check("err_cleared_by_start", 32'(o_error), 32'(0));
    check("tmo_cleared_by_start", 32'(o_timeout), 32'(0));
    for (int i = 0; i < wt; i++) begin
      tick();
      check("no_resp_while_waiting", 32'(o_sb_resp_valid), 32'(0));
    end
    i_sb_msg_valid = 1'b1;
    i_sb_msg_lanes = rem;
    i_local_lanes  = loc;
    tick();
    i_sb_msg_valid = 1'b0;
    i_sb_msg_lanes = 2'($urandom_range(0, 3));
    i_local_lanes  = 2'($urandom_range(0, 3));
    check("resp_valid", 32'(o_sb_resp_valid), 32'(1));
    check("rx_mask", 32'(o_rx_lane_enable), 32'(erx));
    check("tx_mask", 32'(o_tx_lane_enable), 32'(etx));
    check("resp_code", 32'(o_sb_resp_code), 32'(ecode));
    check("error", 32'(o_error), 32'(eerr));
    check("degraded", 32'(o_width_degraded), 32'(edeg));
    check("no_timeout", 32'(o_timeout), 32'(0));
    exp_q.push_back(ecode);
    for (int c = 0; c < rd; c++) begin
      i_sb_resp_ready = 1'b0;
      if (poke && c == 0) start_apply = 1'b1;
      tick();
      start_apply = 1'b0;
      check("resp_valid_held", 32'(o_sb_resp_valid), 32'(1));
      check("resp_code_stable", 32'(o_sb_resp_code), 32'(ecode));
    end
    i_sb_resp_ready = 1'b1;
    if (o_sb_resp_valid && exp_q.size() > 0) check("xfer_code", 32'(o_sb_resp_code), 32'(exp_q.pop_front()));
    else check("xfer_valid", 32'(o_sb_resp_valid), 32'(1));
    tick();
    i_sb_resp_ready = 1'b0;
    check("valid_dropped", 32'(o_sb_resp_valid), 32'(0));
    check("done_not_yet", 32'(done_apply), 32'(0));
    tick();
    check("done_pulse", 32'(done_apply), 32'(1));
    check("rx_mask_kept", 32'(o_rx_lane_enable), 32'(erx));
    check("tx_mask_kept", 32'(o_tx_lane_enable), 32'(etx));
    tick();
    check("done_one_cycle", 32'(done_apply), 32'(0));
    last_rx = erx;
    last_tx = etx;
  endtask

  task automatic run_timeout();
    i_sb_msg_valid  = 1'b0;
    i_sb_resp_ready = 1'($urandom_range(0, 1));
    start_apply = 1'b1;
    tick();
    start_apply = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      check("tmo_early", 32'(o_timeout), 32'(0));
      check("tmo_no_resp", 32'(o_sb_resp_valid), 32'(0));
    end
    tick();
    check("tmo_flag", 32'(o_timeout), 32'(1));
    check("tmo_error", 32'(o_error), 32'(1));
    check("tmo_done_not_yet", 32'(done_apply), 32'(0));
    tick();
    check("tmo_done_pulse", 32'(done_apply), 32'(1));
    check("tmo_no_resp_end", 32'(o_sb_resp_valid), 32'(0));
    check("tmo_rx_unchanged", 32'(o_rx_lane_enable), 32'(last_rx));
    check("tmo_tx_unchanged", 32'(o_tx_lane_enable), 32'(last_tx));
    tick();
    check("tmo_done_one_cycle", 32'(done_apply), 32'(0));
    check("tmo_sticky", 32'(o_timeout), 32'(1));
  endtask

  // Directed vector table
  typedef struct {
    logic [1:0]    rem;
    logic [1:0]    loc;
    int            wt;
    int            rd;
    bit            poke;
    logic [NL-1:0] rx;
    logic [NL-1:0] tx;
    logic [1:0]    code;
    bit            err;
    bit            deg;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [NL-1:0] erx, etx;
    logic [1:0]    ecode, rem, loc;
    bit            eerr, edeg;

`ifdef FLA_SYMMETRIC_EN
    vecs[0] = '{2'b11, 2'b11, 0,  0, 1'b0, 16'hFFFF, 16'hFFFF, 2'b01, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 2'b01, 2,  5, 1'b1, 16'h0000, 16'h0000, 2'b10, 1'b1, 1'b1};
    vecs[2] = '{2'b00, 2'b11, 1,  2, 1'b0, 16'h0000, 16'h0000, 2'b10, 1'b1, 1'b1};
    vecs[3] = '{2'b01, 2'b01, 15, 1, 1'b0, 16'h00FF, 16'h00FF, 2'b01, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 2'b00, 3,  3, 1'b1, 16'h0000, 16'h0000, 2'b10, 1'b1, 1'b1};
    vecs[5] = '{2'b11, 2'b10, 0,  0, 1'b0, 16'hFF00, 16'hFF00, 2'b01, 1'b0, 1'b1};
`else
    vecs[0] = '{2'b11, 2'b11, 0,  0, 1'b0, 16'hFFFF, 16'hFFFF, 2'b01, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 2'b01, 2,  5, 1'b1, 16'hFF00, 16'h00FF, 2'b01, 1'b0, 1'b1};
    vecs[2] = '{2'b00, 2'b11, 1,  2, 1'b0, 16'h0000, 16'hFFFF, 2'b10, 1'b1, 1'b1};
    vecs[3] = '{2'b01, 2'b01, 15, 1, 1'b0, 16'h00FF, 16'h00FF, 2'b01, 1'b0, 1'b1};
    vecs[4] = '{2'b11, 2'b00, 3,  3, 1'b1, 16'hFFFF, 16'h0000, 2'b10, 1'b1, 1'b1};
    vecs[5] = '{2'b11, 2'b10, 0,  0, 1'b0, 16'hFFFF, 16'hFF00, 2'b01, 1'b0, 1'b1};
`endif

    // Reset
    rst_n = 1'b0;
    start_apply = 1'b0;
    i_local_lanes = 2'b00;
    i_sb_msg_valid = 1'b0;
    i_sb_msg_lanes = 2'b00;
    i_sb_resp_ready = 1'b0;
    repeat (3) tick();
    check("rst_rx", 32'(o_rx_lane_enable), 32'hFFFF);
    check("rst_tx", 32'(o_tx_lane_enable), 32'hFFFF);
    check("rst_valid", 32'(o_sb_resp_valid), 32'(0));
    check("rst_code", 32'(o_sb_resp_code), 32'(0));
    check("rst_done", 32'(done_apply), 32'(0));
    check("rst_error", 32'(o_error), 32'(0));
    check("rst_timeout", 32'(o_timeout), 32'(0));
    check("rst_degraded", 32'(o_width_degraded), 32'(0));
    rst_n = 1'b1;
    tick();

    // Message in IDLE is dropped; the following attempt then times out.
    i_sb_msg_valid = 1'b1;
    i_sb_msg_lanes = 2'b00;
    i_local_lanes  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_msg_no_resp", 32'(o_sb_resp_valid), 32'(0));
      check("idle_msg_rx", 32'(o_rx_lane_enable), 32'hFFFF);
      check("idle_msg_tx", 32'(o_tx_lane_enable), 32'hFFFF);
    end
    run_timeout();

    // Directed table
    foreach (vecs[i])
      run_txn(vecs[i].rem, vecs[i].loc, vecs[i].wt, vecs[i].rd, vecs[i].poke,
              vecs[i].rx, vecs[i].tx, vecs[i].code, vecs[i].err, vecs[i].deg);

    // Timeout with non-default masks held
    run_timeout();

    // Reset while a response is pending
    i_sb_resp_ready = 1'b0;
    start_apply = 1'b1;
    tick();
    start_apply = 1'b0;
    i_sb_msg_valid = 1'b1;
    i_sb_msg_lanes = 2'b01;
    i_local_lanes  = 2'b10;
    tick();
    i_sb_msg_valid = 1'b0;
    check("pre_rst_valid", 32'(o_sb_resp_valid), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_sb_resp_valid), 32'(0));
    check("async_rst_rx", 32'(o_rx_lane_enable), 32'hFFFF);
    check("async_rst_tx", 32'(o_tx_lane_enable), 32'hFFFF);
    check("async_rst_code", 32'(o_sb_resp_code), 32'(0));
    check("async_rst_error", 32'(o_error), 32'(0));
    check("async_rst_degraded", 32'(o_width_degraded), 32'(0));
    tick();
    rst_n = 1'b1;
    last_rx = '1;
    last_tx = '1;
    tick();
    check("post_rst_idle_valid", 32'(o_sb_resp_valid), 32'(0));

    // Randomized transactions against the model
    for (int n = 0; n < 30; n++) begin
      rem = 2'($urandom_range(0, 3));
      loc = 2'($urandom_range(0, 3));
      model(rem, loc, erx, etx, ecode, eerr, edeg);
      run_txn(rem, loc, $urandom_range(0, 5), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), erx, etx, ecode, eerr, edeg);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
